// File: rtl/butterfly_mult_seq.sv
// Sequential shift-add signed multiplier for the FFT butterfly datapath.
// It processes one multiplier bit per clock on operand magnitudes and then
// applies the sign. It delivers the full product plus a rounded, shifted and
// saturated fixed-point result.
module butterfly_mult_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = WIDTH - 1
) (
  input  logic                      xClk,
  input  logic                      xRst_n,
  input  logic                      xInValid,
  output logic                      xInReady,
  input  logic signed [WIDTH-1:0]   xMultiplicand,
  input  logic signed [WIDTH-1:0]   xMultiplier,
  output logic                      xOutValid,
  input  logic                      xOutReady,
  output logic signed [2*WIDTH-1:0] xProduct,
  output logic signed [WIDTH-1:0]   xScaled,
  output logic                      xSat
);

  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int HALF_SH = (FRAC > 0) ? FRAC - 1 : 0;

  // Scaling works one bit wider than the product, so adding the rounding
  // constant can never wrap.
  localparam logic signed [2*WIDTH:0] ONE  = 1;
  localparam logic signed [2*WIDTH:0] HALF = (FRAC > 0) ? (ONE <<< HALF_SH) : '0;
  localparam logic signed [2*WIDTH:0] SMAX = (ONE <<< (WIDTH - 1)) - ONE;
  localparam logic signed [2*WIDTH:0] SMIN = -(ONE <<< (WIDTH - 1));

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand_p0;   // |A|
  logic [WIDTH-1:0]   acc_p0;     // upper half of the running product
  logic [WIDTH-1:0]   mplr_p0;    // |B|, shifted out as the lower half fills
  logic               sign_p0;
  logic [CNT_W-1:0]   cnt_p0;

  logic [WIDTH:0]            sum;
  logic [WIDTH-1:0]          acc_nxt;
  logic [WIDTH-1:0]          mplr_nxt;
  logic [2*WIDTH-1:0]        mag;
  logic signed [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]            scl;

  // Magnitude as unsigned; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  // Round half toward +inf, arithmetic shift by FRAC, then clip.
  // Returns {sat, scaled}.
  function automatic logic [WIDTH:0] scale(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH:0] ext;
    logic signed [2*WIDTH:0] t;
    logic [WIDTH:0]          r;
    ext = {p[2*WIDTH-1], p};
    t   = (ext + HALF) >>> FRAC;
    if (t > SMAX)      r = {1'b1, SMAX[WIDTH-1:0]};
    else if (t < SMIN) r = {1'b1, SMIN[WIDTH-1:0]};
    else               r = {1'b0, t[WIDTH-1:0]};
    return r;
  endfunction

  // One shift-add step and the finished result derived from it.
  always_comb begin
    sum      = {1'b0, acc_p0} + (mplr_p0[0] ? {1'b0, mcand_p0} : '0);
    acc_nxt  = sum[WIDTH:1];
    mplr_nxt = {sum[0], mplr_p0[WIDTH-1:1]};
    mag      = {acc_nxt, mplr_nxt};
    prod_nxt = sign_p0 ? -$signed(mag) : $signed(mag);
    scl      = scale(prod_nxt);
  end

  assign xInReady  = (state == IDLE);
  assign xOutValid = (state == DONE);

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) begin
      state    <= IDLE;
      mcand_p0 <= '0;
      acc_p0   <= '0;
      mplr_p0  <= '0;
      sign_p0  <= 1'b0;
      cnt_p0   <= '0;
      xProduct <= '0;
      xScaled  <= '0;
      xSat     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xInValid) begin
            mcand_p0 <= abs_val(xMultiplicand);
            mplr_p0  <= abs_val(xMultiplier);
            sign_p0  <= xMultiplicand[WIDTH-1] ^ xMultiplier[WIDTH-1];
            acc_p0   <= '0;
            cnt_p0   <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc_p0  <= acc_nxt;
          mplr_p0 <= mplr_nxt;
          cnt_p0  <= cnt_p0 + 1'b1;
          if (cnt_p0 == CNT_W'(WIDTH - 1)) begin
            xProduct <= prod_nxt;
            xScaled  <= scl[WIDTH-1:0];
            xSat     <= scl[WIDTH];
            state    <= DONE;
          end
        end
        DONE: begin
          if (xOutReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/butterfly_mult_seq.md
# butterfly_mult_seq

Parametrised, sequential, signed two's-complement multiplier with valid/ready handshakes on both sides. It replaces the single-cycle combinational multiplier in the FFT butterfly datapath where a full-width array multiplier does not fit. It trades area for latency: one multiplier bit is processed per clock. Alongside the full-precision product it delivers a fixed-point rounded, saturated result for twiddle-factor scaling.

## Interface
- WIDTH, 16, operand width in bits (>= 2).
- FRAC, WIDTH-1, fractional bits removed by the scaled output (0 .. 2*WIDTH-2); the default gives Q1.(WIDTH-1).

- xClk  input  1  clock; all state updates on the rising edge.
- xRst_n  input  1  reset, asynchronous assert, active-low.
- xInValid  input  1  operands present.
- xInReady  output  1  block can accept operands.
- xMultiplicand  input  WIDTH  signed operand A.
- xMultiplier  input  WIDTH  signed operand B.
- xOutValid  output  1  result present.
- xOutReady  input  1  consumer accepts result.
- xProduct  output  2*WIDTH  signed full product A*B.
- xScaled  output  WIDTH  signed product: rounded, arithmetic-shifted right by FRAC, saturated.
- xSat  output  1  xScaled was clipped.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- xInReady is 1 only in IDLE. xOutValid is 1 only in DONE.
- **IDLE to BUSY** on a cycle with xInValid && xInReady.
  - Latch |A| and |B| as WIDTH-bit unsigned values.
  - Latch the result sign A[W-1]^B[W-1].
  - Clear the accumulator and the bit counter.
- **BUSY**, each cycle:
  - If the current LSB of |B| is 1, add |A| to the accumulator's upper half.
  - Shift the {accumulator, |B|} register right by 1.
  - Increment the counter.
  - After WIDTH BUSY cycles, go to DONE and register the outputs.
- **Width rules:**
  - |-2^(W-1)| is held as unsigned 2^(W-1) with no overflow.
  - The unsigned product fits in 2W bits.
  - The sign is applied by two's-complement negation.
  - -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable in xProduct.
  - A zero product is never negated to a nonzero value.
- **Scaling:**
  - Compute t = (P + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half toward +inf). With FRAC=0, t = P.
  - If t > 2^(W-1)-1, xScaled = 2^(W-1)-1 and xSat = 1.
  - If t < -2^(W-1), xScaled = -2^(W-1) and xSat = 1.
  - Otherwise xScaled = t[W-1:0] and xSat = 0.
- **DONE to IDLE** on a cycle with xOutReady = 1.
- xProduct, xScaled and xSat hold their value from entry to DONE until the next entry to DONE.
- Reset values: xInReady=1, xOutValid=0, xProduct=0, xScaled=0, xSat=0, internal registers 0.
- Reset asserted mid-operation (BUSY or DONE):
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The pending result is discarded.
  - The first accept is possible on the first rising edge after xRst_n deasserts.

## Timing
- Accept edge k. BUSY covers edges k+1 .. k+WIDTH. xOutValid rises after edge k+WIDTH, so latency is WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH BUSY cycles, one DONE cycle with xOutReady=1, back in IDLE.
- No operand/result overlap.
- **Backpressure:** while xOutValid=1 and xOutReady=0, the result outputs are stable and xInReady=0.
- Operand inputs are sampled only on the accept edge. They are don't-care at all other times.
- xOutReady is ignored outside DONE. xInValid is ignored outside IDLE.
- No combinational path from any input to any output. xInReady and xOutValid are decoded from registered state only.

## Test plan
Use WIDTH=16 and FRAC=15 unless stated.
1. **Basic multiply.** 0x4000 * 0x4000 -> xProduct=0x10000000, xScaled=0x2000, xSat=0. xOutValid rises exactly 16 cycles after the accept edge.
2. **Most-negative corner.** 0x8000 * 0x8000 -> xProduct=0x40000000, xScaled=0x7FFF, xSat=1. Also 0x8000 * 0x7FFF -> xProduct=0xC0008000, xScaled=0x8001, xSat=0.
3. **Rounding.**
   - 0x0001 * 0x4000 -> xProduct=0x00004000, xScaled=0x0001.
   - 0xFFFF * 0x4000 -> xProduct=0xFFFFC000, xScaled=0x0000.
   - 0x0000 * 0x8000 -> xProduct=0, xScaled=0.
4. **Backpressure.** Hold xOutReady=0 for 10 cycles after xOutValid rises.
   - Outputs stay stable, xInReady=0, and a held xInValid is not accepted.
   - Raise xOutReady for one cycle: the next cycle has xInReady=1 and xOutValid=0.
5. **Reset mid-operation.**
   - Assert xRst_n=0 at BUSY cycle 7 -> xOutValid=0, xProduct=0, xInReady=1 without a clock edge.
   - After release, 3 * -5 -> xProduct=0xFFFFFFF1.
6. **Parameter sweep and random run.**
   - WIDTH=8, FRAC=0: -128 * -128 -> xProduct=0x4000, xScaled=0x7F, xSat=1.
   - Run 10000 random operand pairs with random xInValid/xOutReady stalls, compared against a reference model.
   - Repeat the random run at WIDTH=4, 16 and 24.
